// File: rtl/rejunity_psg_pkg.sv
// Shared constants for the SN76489-compatible PSG: register indices, LFSR seed,
// noise shift rates and the attenuation-to-volume table.
package rejunity_psg_pkg;

   // Register index = {channel[1:0], type}
   localparam logic [2:0] TONE0 = 3'd0;
   localparam logic [2:0] ATT0  = 3'd1;
   localparam logic [2:0] TONE1 = 3'd2;
   localparam logic [2:0] ATT1  = 3'd3;
   localparam logic [2:0] TONE2 = 3'd4;
   localparam logic [2:0] ATT2  = 3'd5;
   localparam logic [2:0] NOISE = 3'd6;
   localparam logic [2:0] ATT3  = 3'd7;

   localparam logic [14:0] LFSR_SEED = 15'h4000;

   localparam logic [6:0] NOISE_RATE_16 = 7'd16;
   localparam logic [6:0] NOISE_RATE_32 = 7'd32;
   localparam logic [6:0] NOISE_RATE_64 = 7'd64;

   // 2 dB steps; index 15 is mute
   localparam logic [5:0] VOL_LUT [16] = '{
      6'd63, 6'd50, 6'd40, 6'd32, 6'd25, 6'd20, 6'd16, 6'd12,
      6'd10, 6'd8,  6'd6,  6'd5,  6'd4,  6'd3,  6'd2,  6'd0
   };

   function automatic logic [6:0] noise_rate(input logic [1:0] sel);
      case (sel)
         2'b00:   return NOISE_RATE_16;
         2'b01:   return NOISE_RATE_32;
         default: return NOISE_RATE_64;
      endcase
   endfunction

endpackage

// File: rtl/rejunity_sn76489_psg_tone.sv
// Square-wave tone generator: 10-bit down-counter reloaded from the period,
// output toggles on each reload; period 0/1 holds the output high (DC).
module psg_tone_gen
   import rejunity_psg_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic [9:0] period,
   output logic       out
);

   logic [9:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         out <= 1'b0;
      end else if (tick) begin
         if (cnt <= 10'd1) begin
            cnt <= period;
            out <= (period <= 10'd1) ? 1'b1 : ~out;
         end else begin
            cnt <= cnt - 10'd1;
         end
      end
   end

endmodule

// File: rtl/rejunity_sn76489_psg.sv
// SN76489-compatible PSG: three tone channels, one LFSR noise channel, 8-bit mix.
// Define PSG_CHANNEL_TAPS_EN to export raw channel bits on uio_out[7:4].
module rejunity_sn76489_psg
   import rejunity_psg_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   localparam int PW = $clog2(CLK_DIV);

   logic [PW-1:0]   prescale;
   logic            tick;
   logic            wr_raw;
   logic [2:0]      wr_sync;
   logic            wr_pulse;
   logic [2:0]      latched;
   logic [2:0]      addr;
   logic            noise_wr;
   logic [2:0][9:0] period;
   logic [3:0][3:0] att;
   logic [2:0]      noise_ctrl;
   logic [6:0]      noise_cnt;
   logic [14:0]     lfsr;
   logic            fb;
   logic            shift_en;
   logic            tone2_prev;
   logic [2:0]      tone_out;
   logic [7:0]      mix;
   logic            unused_bits;

   assign unused_bits = &{ena, uio_in[7:2]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prescale <= '0;
      else        prescale <= prescale + PW'(1);
   end
   assign tick = &prescale;

   // Strobe is asynchronous to clk; a write fires once per synchronised rising edge
   assign wr_raw   = ~uio_in[0] & ~uio_in[1];
   assign wr_pulse = wr_sync[1] & ~wr_sync[2];
   assign addr     = ui_in[7] ? ui_in[6:4] : latched;
   assign noise_wr = wr_pulse && (addr == NOISE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_sync    <= '0;
         latched    <= TONE0;
         period     <= '0;
         att        <= {4{4'hF}};
         noise_ctrl <= '0;
      end else begin
         wr_sync <= {wr_sync[1:0], wr_raw};
         if (wr_pulse) begin
            if (ui_in[7]) latched <= ui_in[6:4];
            case (addr)
               TONE0, TONE1, TONE2: begin
                  if (ui_in[7]) period[addr[2:1]][3:0] <= ui_in[3:0];
                  else          period[addr[2:1]][9:4] <= ui_in[5:0];
               end
               NOISE:   noise_ctrl <= ui_in[2:0];
               default: att[addr[2:1]] <= ui_in[3:0];
            endcase
         end
      end
   end

   for (genvar g = 0; g < 3; g++) begin : g_tone
      psg_tone_gen u_tone (
         .clk    (clk),
         .rst_n  (rst_n),
         .tick   (tick),
         .period (period[g]),
         .out    (tone_out[g])
      );
   end

   assign fb       = noise_ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0];
   assign shift_en = (noise_ctrl[1:0] == 2'b11) ? (tone_out[2] & ~tone2_prev)
                                                : (tick && (noise_cnt <= 7'd1));

   // A control write reseeds the LFSR even if a shift lands on the same clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         noise_cnt  <= '0;
         lfsr       <= LFSR_SEED;
         tone2_prev <= 1'b0;
      end else begin
         tone2_prev <= tone_out[2];
         if (tick) noise_cnt <= (noise_cnt <= 7'd1) ? noise_rate(noise_ctrl[1:0])
                                                    : noise_cnt - 7'd1;
         if (noise_wr)      lfsr <= LFSR_SEED;
         else if (shift_en) lfsr <= {fb, lfsr[14:1]};
      end
   end

   always_comb begin
      mix = '0;
      for (int i = 0; i < 3; i++)
         if (tone_out[i]) mix = mix + {2'b00, VOL_LUT[att[i]]};
      if (lfsr[0]) mix = mix + {2'b00, VOL_LUT[att[3]]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) uo_out <= '0;
      else        uo_out <= mix;
   end

`ifdef PSG_CHANNEL_TAPS_EN
   assign uio_out = {lfsr[0], tone_out[2], tone_out[1], tone_out[0], 4'h0};
   assign uio_oe  = 8'hF0;
`else
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_rejunity_sn76489_psg.sv
// Self-checking bench for rejunity_sn76489_psg: vector table, randomized mix
// against a register/volume model, and timed tone/noise/strobe sequences.
module tb_rejunity_sn76489_psg;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b1;
   logic       ena    = 1'b1;
   logic [7:0] ui_in  = 8'h00;
   logic [7:0] uio_in = 8'h03;
   wire  [7:0] uio_out;
   wire  [7:0] uio_oe;
   wire  [7:0] uo_out;

   int tests = 0;
   int fails = 0;
   int vol [16] = '{63, 50, 40, 32, 25, 20, 16, 12, 10, 8, 6, 5, 4, 3, 2, 0};

   typedef struct {
      logic [7:0] data;
      int         exp;
   } vec_t;
   vec_t vecs [13];

   rejunity_sn76489_psg dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .uo_out  (uo_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      tests++;
      if (act < lo || act > hi) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_bus();
      uio_in = {6'($urandom), 2'($urandom_range(1, 3))};
   endtask

   task automatic write(input logic [7:0] d);
      @(negedge clk);
      ena    = 1'($urandom);
      ui_in  = d;
      uio_in = {6'($urandom), 2'b00};
      clocks(4);
      release_bus();
      clocks(4);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      clocks(3);
      rst_n = 1'b1;
      clocks(2);
   endtask

   task automatic wait_change(input int budget, output int n, output bit ok);
      logic [7:0] prev;
      prev = uo_out;
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk);
         n++;
         if (uo_out != prev) ok = 1'b1;
      end
   endtask

   task automatic wait_value(input logic [7:0] v, input int budget, output int n, output bit ok);
      n  = 0;
      ok = (uo_out == v);
      while (n < budget && !ok) begin
         @(negedge clk);
         n++;
         if (uo_out == v) ok = 1'b1;
      end
   endtask

   function automatic logic [14:0] lfsr_step(input logic [14:0] s, input bit white);
      logic f;
      f = white ? (s[0] ^ s[1]) : s[0];
      return {f, s[14:1]};
   endfunction

   initial begin
      int         n, n2, exp;
      bit         ok;
      int         m_att [3];
      int         m_lat;
      logic [14:0] m_lfsr;

      vecs[0]  = '{8'h90, 63};
      vecs[1]  = '{8'hB2, 103};
      vecs[2]  = '{8'hBF, 63};
      vecs[3]  = '{8'hD0, 126};
      vecs[4]  = '{8'h05, 83};
      vecs[5]  = '{8'hA0, 83};
      vecs[6]  = '{8'hB0, 146};
      vecs[7]  = '{8'h0F, 83};
      vecs[8]  = '{8'h9F, 20};
      vecs[9]  = '{8'h80, 20};
      vecs[10] = '{8'h00, 20};
      vecs[11] = '{8'hB7, 32};
      vecs[12] = '{8'h0A, 26};

      // Reset state
      #2 rst_n = 1'b0;
      clocks(3);
      check("reset_uo_out", uo_out, 0);
`ifdef PSG_CHANNEL_TAPS_EN
      check("reset_uio_oe", uio_oe, 8'hF0);
`else
      check("reset_uio_oe", uio_oe, 0);
`endif
      check("reset_uio_out", uio_out, 0);
      rst_n = 1'b1;
      clocks(100);
      check("silent_after_reset", uo_out, 0);

      // Vector table, applied in sequence from reset
      for (int i = 0; i < 13; i++) begin
         write(vecs[i].data);
         clocks(40);
         check($sformatf("vec%0d_%02h", i, vecs[i].data), uo_out, vecs[i].exp);
      end

      // Randomized writes against a register-level model (tones held at DC)
      do_reset();
      m_att = '{15, 15, 15};
      m_lat = 0;
      for (int it = 0; it < 25; it++) begin
         int op, ch, v;
         logic [7:0] b;
         op = $urandom_range(0, 2);
         ch = $urandom_range(0, 2);
         v  = $urandom_range(0, 15);
         case (op)
            0: begin
               b = {1'b1, 2'(ch), 1'b1, 4'(v)};
               m_att[ch] = v;
               m_lat = 2 * ch + 1;
            end
            1: begin
               if (m_lat % 2 == 1) begin
                  b = {1'b0, 3'($urandom), 4'(v)};
                  m_att[m_lat / 2] = v;
               end else begin
                  b = {1'b0, 1'($urandom), 6'd0};
               end
            end
            default: begin
               b = {1'b1, 2'(ch), 1'b0, 3'd0, 1'($urandom)};
               m_lat = 2 * ch;
            end
         endcase
         write(b);
         clocks(40);
         exp = vol[m_att[0]] + vol[m_att[1]] + vol[m_att[2]];
         check($sformatf("rand%0d_%02h", it, b), uo_out, exp);
      end

      // Tone ch0, period 2: half-period 32 clks
      do_reset();
      write(8'h90);
      write(8'h82);
      write(8'h00);
      wait_change(200, n, ok);
      check("tone_sync", ok, 1);
      wait_change(200, n, ok);
      check("tone_half1", n, 32);
      exp = uo_out;
      wait_change(200, n, ok);
      check("tone_half2", n, 32);
      check("tone_levels", exp + uo_out, 63);
      check("tone_uio_out", uio_out & 8'h0F, 0);

      // Async reset while the tone is high
      wait_value(8'd63, 100, n, ok);
      check("midreset_seen_high", ok, 1);
      #2 rst_n = 1'b0;
      #1 check("midreset_uo_out", uo_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      clocks(100);
      check("midreset_silent", uo_out, 0);
      write(8'h90);
      clocks(40);
      check("midreset_dc", uo_out, 63);

      // Data byte extends period to 0x01F: half-period 496 clks
      write(8'h8F);
      write(8'h01);
      wait_change(1200, n, ok);
      check("data_sync", ok, 1);
      wait_change(1200, n, ok);
      check("data_half1", n, 496);
      wait_change(1200, n, ok);
      check("data_half2", n, 496);

      // White noise at rate 16 against an LFSR model
      do_reset();
      write(8'hF0);
      write(8'hE4);
      wait_value(8'd63, 4200, n, ok);
      check("white_first_rise", ok, 1);
      check_range("white_rise_time", n, 3320, 3590);
      m_lfsr = 15'h4000;
      repeat (14) m_lfsr = lfsr_step(m_lfsr, 1'b1);
      clocks(128);
      for (int k = 0; k < 24; k++) begin
         check($sformatf("white_shift%0d", 14 + k), uo_out, m_lfsr[0] ? 63 : 0);
         m_lfsr = lfsr_step(m_lfsr, 1'b1);
         clocks(256);
      end

      // Periodic noise: one high shift every 15 shifts
      do_reset();
      write(8'hF0);
      write(8'hE0);
      wait_value(8'd63, 4200, n, ok);
      check("periodic_rise", ok, 1);
      wait_change(600, n, ok);
      check("periodic_high_len", n, 256);
      check("periodic_low_val", uo_out, 0);
      wait_change(4000, n2, ok);
      check("periodic_low_len", n2, 3584);
      check("periodic_high_val", uo_out, 63);

      // Held strobe performs one write only
      do_reset();
      @(negedge clk);
      ui_in  = 8'h90;
      uio_in = 8'h00;
      clocks(100);
      check("hold_att_write", uo_out, 63);
      release_bus();
      clocks(4);
      write(8'h9F);
      write(8'hF0);
      clocks(4);
      @(negedge clk);
      ui_in  = 8'hE0;
      uio_in = 8'h00;
      wait_value(8'd63, 4000, n, ok);
      check("hold_noise_single_reload", ok, 1);
      release_bus();
      clocks(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
